// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Signal bundle between the execute stage (master) and the data-memory
// responder (slave).
//
//   load_mode[2]   master->slave  per-port access kind (see mode codes below)
//   load_addr[2]   master->slave  per-port byte address
//   load_data[2]   slave->master  per-port load result, combinational
//   st_valid       master->slave  committed store offered
//   st_ready       slave->master  store buffer can accept
//   st_mode        master->slave  store width (unsigned kinds = same width)
//   st_addr        master->slave  store byte address
//   st_data        master->slave  store data, low bytes used for byte/half
//   drain_hold     master->slave  1 = RAM write port stalled this cycle
//   sb_count       slave->master  store-buffer occupancy
//   st_misaligned  slave->master  one-cycle pulse: last store dropped
//
// Mode codes: 0 byte, 1 half, 2 word, 3 byte-unsigned, 4 half-unsigned,
// anything else = no access.
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
  parameter int SB_DEPTH = 4
);
  localparam int CW = $clog2(SB_DEPTH) + 1;

  logic [2:0]    load_mode [2];
  logic [31:0]   load_addr [2];
  logic [31:0]   load_data [2];
  logic          st_valid;
  logic          st_ready;
  logic [2:0]    st_mode;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic          drain_hold;
  logic [CW-1:0] sb_count;
  logic          st_misaligned;

  modport master (
    output load_mode, load_addr, st_valid, st_mode, st_addr, st_data, drain_hold,
    input  load_data, st_ready, sb_count, st_misaligned
  );

  modport slave (
    input  load_mode, load_addr, st_valid, st_mode, st_addr, st_data, drain_hold,
    output load_data, st_ready, sb_count, st_misaligned
  );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder behind the execute stage's load interface.
//   - Two independent combinational load ports.
//   - Committed stores enter an in-order store buffer (SB_DEPTH entries) that
//     drains one entry per cycle into a word-organised RAM (MEM_WORDS words).
//   - Loads merge RAM data with buffered stores per byte, youngest entry wins.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (empties the buffer, RAM untouched)
//   bus    dmem_responder_if.slave, see the interface file for member list
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int SB_DEPTH  = 4
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] MODE_BYTE   = 3'd0;
  localparam logic [2:0] MODE_HALF   = 3'd1;
  localparam logic [2:0] MODE_WORD   = 3'd2;
  localparam logic [2:0] MODE_BYTE_U = 3'd3;
  localparam logic [2:0] MODE_HALF_U = 3'd4;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_NONE} size_e;

  function automatic size_e load_size(input logic [2:0] mode);
    case (mode)
      MODE_BYTE, MODE_BYTE_U: return SZ_BYTE;
      MODE_HALF, MODE_HALF_U: return SZ_HALF;
      MODE_WORD:              return SZ_WORD;
      default:                return SZ_NONE;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] a);
    return ((size == SZ_HALF) && a[0]) || ((size == SZ_WORD) && (a != 2'b00));
  endfunction

  // Select and extend the addressed lane(s) of an already merged word.
  function automatic logic [31:0] extract(input logic [2:0] mode, input logic [1:0] a,
                                          input logic [31:0] w);
    logic [7:0]  b_sel;
    logic [15:0] h_sel;
    b_sel = w[{a, 3'b000} +: 8];
    h_sel = a[1] ? w[31:16] : w[15:0];
    case (mode)
      MODE_BYTE:   return {{24{b_sel[7]}}, b_sel};
      MODE_BYTE_U: return {24'd0, b_sel};
      MODE_HALF:   return {{16{h_sel[15]}}, h_sel};
      MODE_HALF_U: return {16'd0, h_sel};
      MODE_WORD:   return w;
      default:     return 32'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0]   mem_q     [MEM_WORDS];
  logic [AW-1:0] sb_idx_q  [SB_DEPTH];
  logic [3:0]    sb_be_q   [SB_DEPTH];
  logic [31:0]   sb_data_q [SB_DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          mis_q, mis_d;

  // Address bits above the RAM index alias (wrap) and are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.st_addr[31:AW+2],
                              bus.load_addr[0][31:AW+2], bus.load_addr[1][31:AW+2]};

  // ---------------------------------------------------------------------------
  // Store decode: lane-align the data and build the byte enables.
  // Unsigned store kinds and unknown codes are taken as their plain widths
  // (unknown = word).
  // ---------------------------------------------------------------------------
  size_e         st_size_c;
  logic          st_mis_c;
  logic [3:0]    st_be_c;
  logic [31:0]   st_lane_c;
  logic [AW-1:0] st_idx_c;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    st_size_c = load_size(bus.st_mode);
    if (st_size_c == SZ_NONE) st_size_c = SZ_WORD;
    st_mis_c  = is_misaligned(st_size_c, bus.st_addr[1:0]);
    st_idx_c  = bus.st_addr[AW+1:2];
    st_be_c   = 4'b1111;
    st_lane_c = bus.st_data;
    case (st_size_c)
      SZ_BYTE: begin
        st_be_c   = 4'b0001 << bus.st_addr[1:0];
        st_lane_c = {4{bus.st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be_c   = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        st_lane_c = {2{bus.st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Buffer control. st_ready looks only at the registered count, so a drain in
  // the same cycle never makes room early.
  // ---------------------------------------------------------------------------
  logic st_ready_c, accept, push, pop;

  assign st_ready_c = (count_q < CW'(SB_DEPTH));

  always_comb begin
    accept  = bus.st_valid & st_ready_c;
    push    = accept & ~st_mis_c;
    pop     = (count_q != '0) & ~bus.drain_hold;
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    mis_d   = accept & st_mis_c;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mis_q   <= mis_d;
    end
  end

  // NOTE: buffer payload and RAM have no reset; validity is carried entirely
  // by head/count, and resetting arrays would block RAM inference.
  always_ff @(posedge clk) begin
    if (push) begin
      sb_idx_q[tail_q]  <= st_idx_c;
      sb_be_q[tail_q]   <= st_be_c;
      sb_data_q[tail_q] <= st_lane_c;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      for (int b = 0; b < 4; b++) begin
        if (sb_be_q[head_q][b]) begin
          mem_q[sb_idx_q[head_q]][8*b +: 8] <= sb_data_q[head_q][8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load ports. Entries are walked oldest (head) to youngest so a later match
  // overwrites an earlier one per byte. The entry draining this cycle is still
  // counted; an entry being pushed this cycle is not yet in count_q.
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [AW-1:0] ld_idx;
    logic [31:0]   merged;
    size_e         ld_size;

    assign ld_idx = bus.load_addr[p][AW+1:2];

    always_comb begin
      merged  = mem_q[ld_idx];
      ld_size = load_size(bus.load_mode[p]);
      for (int k = 0; k < SB_DEPTH; k++) begin
        if ((CW'(k) < count_q) && (sb_idx_q[head_q + PW'(k)] == ld_idx)) begin
          for (int b = 0; b < 4; b++) begin
            if (sb_be_q[head_q + PW'(k)][b]) begin
              merged[8*b +: 8] = sb_data_q[head_q + PW'(k)][8*b +: 8];
            end
          end
        end
      end
    end

    assign bus.load_data[p] =
      ((ld_size == SZ_NONE) || is_misaligned(ld_size, bus.load_addr[p][1:0]))
        ? 32'd0 : extract(bus.load_mode[p], bus.load_addr[p][1:0], merged);
  end

  assign bus.st_ready      = st_ready_c;
  assign bus.sb_count      = count_q;
  assign bus.st_misaligned = mis_q;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the execute stage's load interface.
- Serves two combinational load ports: `load_mode[i]`/`load_addr[i]` in, `load_data[i]` back in the same cycle.
- Accepts committed (non-speculative) stores into an in-order store buffer, which drains one entry per cycle into a word-organised RAM.
- Loads see buffered stores through byte-granular, youngest-wins forwarding.

Parameters:
MEM_WORDS, 1024, RAM depth in 32-bit words; word index = addr[log2(MEM_WORDS)+1:2], upper address bits ignored (wrap).
SB_DEPTH, 4, store-buffer entries (power of two, >=2).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
load_mode  input  ldst_mode[2]  per-port access kind: byte, half, word, byte-unsigned, half-unsigned; any other value = no access.
load_addr  input  32[2]  per-port byte address.
load_data  output  32[2]  per-port result, combinational.
st_valid  input  1  committed store offered.
st_ready  output  1  buffer can accept; transfer when st_valid & st_ready at posedge.
st_mode  input  ldst_mode  store width: byte, half or word (unsigned kinds treated as same width).
st_addr  input  32  store byte address.
st_data  input  32  store data, low bytes used for byte/half.
drain_hold  input  1  1 = RAM write port stalled, no drain this cycle.
sb_count  output  log2(SB_DEPTH)+1  current buffer occupancy.
st_misaligned  output  1  one-cycle pulse: offered store was misaligned and dropped.

Behaviour:
- Reset (async, rst_n=0):
  - Buffer emptied: head=tail=0, sb_count=0, st_ready=1, st_misaligned=0.
  - RAM contents are not reset.
  - Stores buffered at reset are lost, never written to RAM.
- Buffer entry fields: word index, 4-bit byte enable, 32-bit lane-aligned data.
  - byte: be=1<<addr[1:0], data replicated to lane.
  - half: be=0011/1100 by addr[1].
  - word: be=1111.
- Accept:
  - st_ready = (sb_count < SB_DEPTH), a function of registered count only.
  - A drain in the same cycle does not free a slot early.
  - Push written at posedge.
- Misaligned stores (half with addr[0]=1, word with addr[1:0]!=0):
  - st_ready still obeyed; on transfer the store is not buffered.
  - st_misaligned=1 for the next cycle only.
- Drain: each posedge where sb_count>0 and drain_hold=0, the head entry's enabled bytes are written into RAM and the head is popped.
- Simultaneous push+pop: count unchanged, both pointers advance, modulo SB_DEPTH wrap.
- Load path, per port, independent and purely combinational:
  - w = RAM word at load word index.
  - For each byte lane b, take the youngest buffer entry (nearest tail) with matching word index and be[b]=1; otherwise w[b].
  - The head entry being drained this cycle still forwards.
  - A store pushed this cycle is not visible until the next cycle.
- Extract from the merged word:
  - byte: lane addr[1:0], sign-extended.
  - byte-unsigned: same lane, zero-extended.
  - half: lanes by addr[1], sign-extended.
  - half-unsigned: same lanes, zero-extended.
  - word: merged word as-is.
- Misaligned load (same rule as stores) or no-access mode: load_data=0.
- Both ports may hit the same word or buffer entry in the same cycle; no arbitration, no stall.
- Latency:
  - Load: 0 cycles.
  - Store visible to loads: 1 cycle after transfer.
  - Store in RAM: after drain, at earliest the posedge after transfer.

Test Plan:
1. Word store 0xDEADBEEF @0x100 accepted; next cycle word load port0 @0x100 -> 0xDEADBEEF (forwarded). After drain, same load -> 0xDEADBEEF from RAM.
2. After 1, byte store 0x80 @0x101 with drain_hold=1; next cycle:
   - port0 byte @0x101 -> 0xFFFFFF80
   - port1 byte-unsigned @0x101 -> 0x00000080
   - word @0x100 -> 0xDEAD80EF
3. drain_hold=1, push 4 word stores 0x1..0x4 to @0x200 -> sb_count=4, st_ready=0, 5th offer not taken, word load @0x200 -> 0x4 (youngest). Release hold -> count drops 1 per cycle to 0; final RAM @0x200=0x4.
4. Half load @0x103 -> 0. Word store @0x102 -> st_misaligned=1 for exactly one cycle, sb_count unchanged, @0x100 contents unchanged.
5. drain_hold=1, 3 stores buffered to @0x300 (RAM previously 0x11111111). Assert rst_n=0 mid-cycle -> sb_count=0 and st_ready=1 immediately. After release, word load @0x300 -> 0x11111111.
6. Push/pop same cycle at pointer wrap (SB_DEPTH pushes with hold toggling) -> count stable, FIFO order preserved, RAM final values match store order.
